// File: rtl/ex_muldiv_unit.sv
// ============================================================================
//  Module      : ex_muldiv_unit
//  Description : Execute-stage iterative RV32M multiply/divide unit. Accepts
//                one M-extension operation at a time, stalls the pipeline via
//                busy_o and presents a registered result with a one-cycle
//                done_o pulse.
//                Optional feature macro: MULDIV_FAST_MUL_EN
//                  defined   - multiplies use one combinational 33x33 signed
//                              product and complete through the fast path
//                  undefined - multiplies run the 32-step shift-add datapath
//  Ports       : clk       - pipeline clock, rising edge
//                reset_n   - asynchronous active-low reset
//                start_i   - valid M-extension operation in ID/EX
//                op_i      - RV32M funct3 (MUL..REMU)
//                op_a_i    - rs1 value
//                op_b_i    - rs2 value
//                flush_i   - abort any operation in flight
//                busy_o    - stall request to the hazard unit
//                done_o    - one-cycle pulse, result_o valid
//                result_o  - registered result
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] C_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] C_ALL_ONES = {XLEN{1'b1}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [4:0]        r_cnt;
    logic [2:0]        r_op;
    logic              r_neg;      // final result must be negated
    logic [XLEN-1:0]   r_b;        // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] r_acc;      // mul: {partial, multiplier}; div: {rem, quo}
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_finish;

    // ------------------------------------------------------------------
    // Operand decode at accept time
    // ------------------------------------------------------------------
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic            w_neg;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_fast;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN-1:0] w_fast_result;

    assign w_is_div   = op_i[2];
    // Unsigned rs1 only for MULHU, DIVU, REMU (funct3 3, 5, 7)
    assign w_a_signed = ~(op_i[0] & (op_i[1] | op_i[2]));
    // MULHSU additionally treats rs2 as unsigned
    assign w_b_signed = w_a_signed & (op_i != 3'd2);
    assign w_a_neg    = w_a_signed & op_a_i[XLEN-1];
    assign w_b_neg    = w_b_signed & op_b_i[XLEN-1];
    assign w_a_mag    = w_a_neg ? (~op_a_i + 1'b1) : op_a_i;
    assign w_b_mag    = w_b_neg ? (~op_b_i + 1'b1) : op_b_i;
    // Remainder takes the dividend's sign; quotient and product the XOR
    assign w_neg      = (w_is_div & op_i[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_div_zero = w_is_div & (op_b_i == '0);
    assign w_div_ovf  = w_is_div & ~op_i[0] & (op_a_i == C_INT_MIN) &
                        (op_b_i == C_ALL_ONES);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_a_ext;
    logic [2*XLEN-1:0] w_b_ext;
    logic [2*XLEN-1:0] w_fast_prod;

    // Sign/zero-extended operands: the low 2*XLEN bits of their product equal
    // the 33x33 signed product for every signedness combination.
    assign w_a_ext     = {{XLEN{w_a_neg}}, op_a_i};
    assign w_b_ext     = {{XLEN{w_b_neg}}, op_b_i};
    assign w_fast_prod = w_a_ext * w_b_ext;
    assign w_fast      = w_div_zero | w_div_ovf | ~w_is_div;

    always_comb begin
        w_fast_result = '0;
        if (w_div_zero) begin
            w_fast_result = op_i[1] ? op_a_i : C_ALL_ONES;
        end else if (w_div_ovf) begin
            w_fast_result = op_i[1] ? '0 : C_INT_MIN;
        end else if (op_i[1:0] == 2'd0) begin
            w_fast_result = w_fast_prod[XLEN-1:0];
        end else begin
            w_fast_result = w_fast_prod[2*XLEN-1:XLEN];
        end
    end
`else
    assign w_fast = w_div_zero | w_div_ovf;

    always_comb begin
        w_fast_result = '0;
        if (w_div_zero) begin
            w_fast_result = op_i[1] ? op_a_i : C_ALL_ONES;
        end else if (w_div_ovf) begin
            w_fast_result = op_i[1] ? '0 : C_INT_MIN;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Iteration step (one bit per clock)
    // ------------------------------------------------------------------
    logic [XLEN:0]     w_rem_shift;
    logic [2*XLEN-1:0] w_acc_nxt;
`ifndef MULDIV_FAST_MUL_EN
    logic [XLEN:0]     w_sum;
`endif

    always_comb begin
        // Partial remainder shifted left; may briefly need XLEN+1 bits
        w_rem_shift = r_acc[2*XLEN-1:XLEN-1];
        w_acc_nxt   = r_acc;
`ifndef MULDIV_FAST_MUL_EN
        w_sum       = '0;
`endif
        if (r_op[2]) begin
            if (w_rem_shift >= {1'b0, r_b}) begin
                w_acc_nxt = {w_rem_shift[XLEN-1:0] - r_b, r_acc[XLEN-2:0], 1'b1};
            end else begin
                w_acc_nxt = {w_rem_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            end
        end
`ifndef MULDIV_FAST_MUL_EN
        else begin
            w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                        (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
            w_acc_nxt = {w_sum, r_acc[XLEN-1:1]};
        end
`endif
    end

    // Final sign fix-up applied to the accumulator after the last step
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_iter_result;

    assign w_prod_fix = r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
    assign w_quo_fix  = r_neg ? (~w_acc_nxt[XLEN-1:0] + 1'b1) : w_acc_nxt[XLEN-1:0];
    assign w_rem_fix  = r_neg ? (~w_acc_nxt[2*XLEN-1:XLEN] + 1'b1)
                              : w_acc_nxt[2*XLEN-1:XLEN];

    always_comb begin
        w_iter_result = '0;
        if (r_op[2]) begin
            w_iter_result = r_op[1] ? w_rem_fix : w_quo_fix;
        end else if (r_op[1:0] == 2'd0) begin
            w_iter_result = w_prod_fix[XLEN-1:0];
        end else begin
            w_iter_result = w_prod_fix[2*XLEN-1:XLEN];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // busy_o asserted combinationally so ID/EX freezes this cycle
                if (start_i && !flush_i) begin
                    w_accept    = 1'b1;
                    busy_o      = 1'b1;
                    w_state_nxt = w_fast ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                busy_o = 1'b1;
                if (flush_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 5'd0) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done_o      = ~flush_i;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= 5'd0;
            r_op     <= 3'd0;
            r_neg    <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op  <= op_i;
            r_neg <= w_neg;
            if (w_is_div) begin
                r_b   <= w_b_mag;
                r_acc <= {{XLEN{1'b0}}, w_a_mag};
            end else begin
                r_b   <= w_a_mag;
                r_acc <= {{XLEN{1'b0}}, w_b_mag};
            end
            if (w_fast) begin
                r_result <= w_fast_result;
            end else begin
                r_cnt <= 5'd31;
            end
        end else if (r_state == S_BUSY && !flush_i) begin
            r_acc <= w_acc_nxt;
            if (r_cnt != 5'd0) begin
                r_cnt <= r_cnt - 5'd1;
            end
            if (w_finish) begin
                r_result <= w_iter_result;
            end
        end
    end

    assign result_o = r_result;

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none

module tb_ex_muldiv_unit;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i    = 3'd0;
    logic [31:0] op_a_i  = 32'd0;
    logic [31:0] op_b_i  = 32'd0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(32)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: RV32M semantics in plain 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 64'd0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Clock edges after the accept edge until done_o is seen
    function automatic int ref_edges(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        bit fast;
        fast = op[2] && ((b == 32'd0) ||
               (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) fast = 1'b1;
`endif
        return fast ? 0 : 32;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] exp_res;
        int          exp_n;
        int          n;
        bit          busy_bad;
        exp_res = ref_result(op, a, b);
        exp_n   = ref_edges(op, a, b);
        @(negedge clk);
        start_i = 1'b1;
        op_i    = op;
        op_a_i  = a;
        op_b_i  = b;
        #1;
        check_val({tag, ".busy_acc"}, 32'(busy_o), 32'd1);
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        n        = 0;
        busy_bad = 1'b0;
        while (!done_o && n < 40) begin
            if (!busy_o) busy_bad = 1'b1;
            // start_i noise while busy must be ignored
            start_i = 1'($urandom_range(0, 1));
            op_i    = 3'($urandom);
            op_a_i  = $urandom;
            op_b_i  = $urandom;
            @(posedge clk);
            #1;
            n++;
        end
        start_i = 1'b0;
        check_val({tag, ".lat"}, 32'(n), 32'(exp_n));
        check_val({tag, ".busy_hold"}, 32'(busy_bad), 32'd0);
        check_val({tag, ".result"}, result_o, exp_res);
        check_val({tag, ".busy_done"}, 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        check_val({tag, ".done_pulse"}, 32'(done_o), 32'd0);
        check_val({tag, ".result_hold"}, result_o, exp_res);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        int          n_done;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.busy", 32'(busy_o), 32'd0);
        check_val("rst.done", 32'(done_o), 32'd0);
        check_val("rst.result", result_o, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed cases
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op("remu_m7_2", 3'd7, 32'hFFFF_FFF9, 32'd2);
        run_op("div_5_0", 3'd4, 32'd5, 32'd0);
        run_op("remu_5_0", 3'd7, 32'd5, 32'd0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op("mul_m1_3", 3'd0, 32'hFFFF_FFFF, 32'd3);
        run_op("mulhsu_neg", 3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_neg", 3'd4, 32'hFFFF_FF9C, 32'd7);

        // Flush during busy cycle 10
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd5; op_a_i = 32'd1000; op_b_i = 32'd7;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        #1;
        check_val("flush.busy_before", 32'(busy_o), 32'd1);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check_val("flush.busy_after", 32'(busy_o), 32'd0);
        n_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_o) n_done++;
        end
        check_val("flush.no_done", 32'(n_done), 32'd0);
        run_op("flush_next_divu", 3'd5, 32'd9, 32'd3);

        // flush_i wins over start_i in IDLE
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; op_i = 3'd4; op_a_i = 32'd5; op_b_i = 32'd0;
        #1;
        check_val("prio.busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        start_i = 1'b0; flush_i = 1'b0;
        check_val("prio.done", 32'(done_o), 32'd0);
        check_val("prio.result", result_o, 32'd3);

        // Randomized operations
        for (int i = 0; i < 80; i++) begin
            r_op = 3'($urandom);
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = 32'd0;
                1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                2: r_b = 32'($urandom_range(1, 15));
                3: r_a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            run_op("rnd", r_op, r_a, r_b);
        end

        // Asynchronous reset mid-operation
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd4; op_a_i = 32'd12345; op_b_i = 32'd17;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_val("arst.busy", 32'(busy_o), 32'd0);
        check_val("arst.done", 32'(done_o), 32'd0);
        check_val("arst.result", result_o, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        n_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_o) n_done++;
        end
        check_val("arst.no_done", 32'(n_done), 32'd0);
        run_op("arst_next_div", 3'd4, 32'd12345, 32'd17);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
